// File: rtl/operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_stage_if
//  Description : Bundles the signals around the operand-fetch stage: the
//                decode-side issue handshake, the writeback port and the
//                execute-side output handshake.
//                slave  modport : seen by operand_stage
//                master modport : seen by the surrounding pipeline
//  Revision    : 1.0  initial release
// ============================================================================
interface operand_stage_if #(
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int REG_SIZE         = 32
);
    // decode -> stage
    logic                        in_valid;
    logic                        in_ready;
    logic [REG_ADDRESS_SIZE-1:0] addr_r1;
    logic [REG_ADDRESS_SIZE-1:0] addr_r2;
    logic [REG_ADDRESS_SIZE-1:0] addr_rd;
    logic                        rd_en;
    logic [REG_SIZE-1:0]         immediate;
    logic                        Ie;
    // writeback -> stage
    logic                        wb_we;
    logic [REG_ADDRESS_SIZE-1:0] wb_addr;
    logic [REG_SIZE-1:0]         wb_data;
    // stage -> execute
    logic                        out_valid;
    logic                        out_ready;
    logic [REG_SIZE-1:0]         operand1;
    logic [REG_SIZE-1:0]         operand2;
    logic [REG_ADDRESS_SIZE-1:0] out_addr_rd;
    logic                        out_rd_en;

    modport slave (
        input  in_valid, addr_r1, addr_r2, addr_rd, rd_en, immediate, Ie,
        input  wb_we, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, operand1, operand2, out_addr_rd, out_rd_en
    );

    modport master (
        output in_valid, addr_r1, addr_r2, addr_rd, rd_en, immediate, Ie,
        output wb_we, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, operand1, operand2, out_addr_rd, out_rd_en
    );
endinterface
`default_nettype wire

// File: rtl/operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_stage
//  Description : Operand-fetch stage between decode and execute. Holds the
//                register bank, a per-register pending-write scoreboard,
//                same-cycle writeback bypass and the operand-2 immediate
//                select. Operands are registered behind a valid/ready
//                handshake; issue stalls on read-after-write hazards.
//  Ports       : clk    - clock, rising edge
//                reset  - synchronous active-high reset
//                bus    - operand_stage_if.slave (issue, writeback, output)
//  Revision    : 1.0  initial release
// ============================================================================
module operand_stage #(
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int REG_SIZE         = 32,
    parameter int ZERO_REG         = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    operand_stage_if.slave  bus
);
    localparam int DEPTH      = 2 ** REG_ADDRESS_SIZE;
    localparam bit c_ZERO_EN  = (ZERO_REG != 0);
    localparam logic [REG_ADDRESS_SIZE-1:0] c_R0 = '0;

    logic [REG_SIZE-1:0]         r_bank [DEPTH];
    logic [DEPTH-1:0]            r_pending;
    logic                        r_out_valid;
    logic [REG_SIZE-1:0]         r_operand1;
    logic [REG_SIZE-1:0]         r_operand2;
    logic [REG_ADDRESS_SIZE-1:0] r_out_addr_rd;
    logic                        r_out_rd_en;

    logic                        w_byp1, w_byp2;
    logic                        w_zero1, w_zero2;
    logic [REG_SIZE-1:0]         w_src1, w_src2;
    logic                        w_hazard1, w_hazard2;
    logic                        w_in_ready;
    logic                        w_accept;
    logic [DEPTH-1:0]            w_pend_set;
    logic [DEPTH-1:0]            w_pend_clr;

    // Source selection: hard zero beats bypass, bypass beats bank contents.
    always_comb begin
        w_byp1  = bus.wb_we && (bus.wb_addr == bus.addr_r1);
        w_byp2  = bus.wb_we && (bus.wb_addr == bus.addr_r2);
        w_zero1 = c_ZERO_EN && (bus.addr_r1 == c_R0);
        w_zero2 = c_ZERO_EN && (bus.addr_r2 == c_R0);

        if (w_zero1)     w_src1 = '0;
        else if (w_byp1) w_src1 = bus.wb_data;
        else             w_src1 = r_bank[bus.addr_r1];

        if (w_zero2)     w_src2 = '0;
        else if (w_byp2) w_src2 = bus.wb_data;
        else             w_src2 = r_bank[bus.addr_r2];

        // A pending source is only a hazard if this cycle's writeback does
        // not deliver it; r2 is irrelevant when the immediate is selected.
        w_hazard1  = r_pending[bus.addr_r1] && !w_byp1;
        w_hazard2  = r_pending[bus.addr_r2] && !w_byp2 && !bus.Ie;
        w_in_ready = !(w_hazard1 || w_hazard2) && (!r_out_valid || bus.out_ready);
        w_accept   = bus.in_valid && w_in_ready;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
            localparam logic [REG_ADDRESS_SIZE-1:0] c_IDX = REG_ADDRESS_SIZE'(gi);
            localparam bit c_LOCKED = c_ZERO_EN && (gi == 0);
            assign w_pend_set[gi] = !c_LOCKED && w_accept && bus.rd_en &&
                                    (bus.addr_rd == c_IDX);
            assign w_pend_clr[gi] = bus.wb_we && (bus.wb_addr == c_IDX);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
            r_pending     <= '0;
            r_out_valid   <= 1'b0;
            r_operand1    <= '0;
            r_operand2    <= '0;
            r_out_addr_rd <= '0;
            r_out_rd_en   <= 1'b0;
        end else begin
            if (bus.wb_we && !(c_ZERO_EN && bus.wb_addr == c_R0))
                r_bank[bus.wb_addr] <= bus.wb_data;

            // Set after clear: a new issue to the same register re-arms it.
            r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;

            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_operand1    <= w_src1;
                r_operand2    <= bus.Ie ? bus.immediate : w_src2;
                r_out_addr_rd <= bus.addr_rd;
                r_out_rd_en   <= bus.rd_en;
            end else if (bus.out_ready) begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.operand1    = r_operand1;
    assign bus.operand2    = r_operand2;
    assign bus.out_addr_rd = r_out_addr_rd;
    assign bus.out_rd_en   = r_out_rd_en;

endmodule
`default_nettype wire
